conv_channel_in_accumulator: RTL and testbench
==============================================

Name: conv_channel_in_accumulator

Overview:
Parametrised successor to the fixed 32x32 stride-2 channel-in adder used after each conv_3x3_top. It accumulates per-input-channel partial convolution planes into one output plane per output channel, with selectable stride decimation, a wide internal accumulator, and saturation to DATA_WIDTH. It sits between conv_3x3_top_NN and the output alignment FIFO in every cnn_conv_NN_3x3 layer wrapper.

Parameters:
DATA_WIDTH, 32, width of the pxl_in and pxl_out samples (signed two's complement)
ACC_WIDTH, 40, internal accumulator width; must be >= DATA_WIDTH + clog2(CHANNEL_NUM_IN)
IMAGE_WIDTH, 32, input plane width in samples
IMAGE_HEIGHT, 32, input plane height in samples
CHANNEL_NUM_IN, 128, number of partial planes summed per output plane
CHANNEL_NUM_OUT, 256, number of output planes per frame
STRIDE, 2, decimation factor; 1 or 2 only
Derived: OUT_W=IMAGE_WIDTH/STRIDE, OUT_H=IMAGE_HEIGHT/STRIDE, OUT_SIZE=OUT_W*OUT_H; OUT_SIZE must be >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
valid_in  input  1  pxl_in is valid this cycle
pxl_in  input  DATA_WIDTH  partial-sum sample, raster order within plane; planes ordered ci=0..CHANNEL_NUM_IN-1, repeated per output channel
pxl_out  output  DATA_WIDTH  accumulated, saturated output sample, raster order
valid_out  output  1  pxl_out valid
plane_done  output  1  one-cycle pulse with the last sample of each output plane
frame_done  output  1  one-cycle pulse with the last sample of output plane CHANNEL_NUM_OUT-1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. No backpressure; valid_in may have arbitrary gaps.
- Reset values: pxl_out=0, valid_out=0, plane_done=0, frame_done=0; all counters 0. The buffer is not cleared.
- Counters advance only on valid_in: col (0..IMAGE_WIDTH-1), row (0..IMAGE_HEIGHT-1), ci (0..CHANNEL_NUM_IN-1), co (0..CHANNEL_NUM_OUT-1). Each wraps into the next; co wraps to 0 after a frame.
- A sample is kept when (row % STRIDE == 0) and (col % STRIDE == 0). Other samples are discarded but still advance the counters. Kept samples address the buffer at idx = (row/STRIDE)*OUT_W + col/STRIDE.
- Buffer: OUT_SIZE x ACC_WIDTH single-port-style RAM, used as a 2-stage read-modify-write.
  - Stage 1: register the address, the sign-extended sample, and the flags first=(ci==0) and last=(ci==CHANNEL_NUM_IN-1).
  - Stage 2:
    - first: write the sample and ignore the old contents.
    - otherwise: sum = old + sample. If last, drive the output and do not write; if not last, write sum.
  - When CHANNEL_NUM_IN==1, first and last are both true, so the sample goes straight to the output.
- Hazard: the same idx recurs at least OUT_SIZE (>=2) kept samples later, so no forwarding is needed. The stage-2 write precedes any later stage-1 read of the same address.
- Output: saturate sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Register it to pxl_out with valid_out=1.
- Latency: exactly 2 cycles from the accepted last-channel kept sample to valid_out. valid_out is 0 on all other cycles and pxl_out holds its last value.
- plane_done is asserted with the output of idx==OUT_SIZE-1. frame_done is additionally conditioned on co==CHANNEL_NUM_OUT-1.
- Reset mid-plane: the pipeline and counters are flushed and the next valid_in is treated as col=row=ci=co=0. Stale buffer contents are harmless because ci=0 overwrites them.
- Simultaneous events: a counter wrap and a new valid_in on the next cycle need no bubble; full throughput is 1 sample/cycle.

Optional Feature:
- Macro CONV_CHANNEL_IN_ACCUMULATOR_RELU_EN.
- Defined: pxl_out = max(0, saturated sum), i.e. negative results are output as 0. Latency is unchanged.
- Undefined: the signed saturated sum is output unchanged.

Test Plan:
- Unit sum: IMAGE 4x4, STRIDE=1, CHANNEL_NUM_IN=4, CHANNEL_NUM_OUT=2. pxl_in=1 every sample -> 32 outputs all =4; plane_done at outputs 16 and 32; frame_done only at output 32; first valid_out 2 cycles after the 49th valid_in.
- Stride 2: IMAGE 4x4, STRIDE=2, CHANNEL_NUM_IN=2. pxl_in = row*4+col, same values both planes -> 4 outputs = 0, 4, 16, 20 in that order.
- Saturation: DATA_WIDTH=8, ACC_WIDTH=12, CHANNEL_NUM_IN=4, every sample 100 -> outputs 127. Every sample -100 -> outputs -128 (0 with RELU_EN).
- Gapped input: the unit-sum case with valid_in toggling 1,0,0 randomly -> identical output values; each valid_out exactly 2 cycles after its triggering valid_in.
- Reset mid-plane: reset asserted after 10 samples of ci=1, then the full unit-sum stimulus -> outputs identical to the unit-sum test; valid_out=0 during and after reset until the new frame's first output.
- RELU: CHANNEL_NUM_IN=2, samples -3 and +1 per pixel -> output -2 without the macro, 0 with CONV_CHANNEL_IN_ACCUMULATOR_RELU_EN defined.

Source files
------------

// File: rtl/conv_channel_in_accumulator.sv
// Sums CHANNEL_NUM_IN partial planes per output plane, with stride decimation and saturation to DATA_WIDTH.
// Latency 2 cycles; no backpressure. Optional ReLU on the output: define CONV_CHANNEL_IN_ACCUMULATOR_RELU_EN.
module conv_channel_in_accumulator #(
  parameter int DATA_WIDTH      = 32,
  parameter int ACC_WIDTH       = 40,
  parameter int IMAGE_WIDTH     = 32,
  parameter int IMAGE_HEIGHT    = 32,
  parameter int CHANNEL_NUM_IN  = 128,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int STRIDE          = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  plane_done,
  output logic                  frame_done
);

  localparam int OUT_W    = IMAGE_WIDTH / STRIDE;
  localparam int OUT_H    = IMAGE_HEIGHT / STRIDE;
  localparam int OUT_SIZE = OUT_W * OUT_H;
  localparam int COL_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int CI_W     = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int CO_W     = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int IDX_W    = $clog2(OUT_SIZE);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [CI_W-1:0]  r_ci;
  logic [CO_W-1:0]  r_co;

  logic             w_col_last;
  logic             w_row_last;
  logic             w_ci_last;
  logic             w_co_last;
  logic             w_keep;
  logic [IDX_W-1:0] w_idx;

  assign w_col_last = (r_col == COL_W'(IMAGE_WIDTH - 1));
  assign w_row_last = (r_row == ROW_W'(IMAGE_HEIGHT - 1));
  assign w_ci_last  = (r_ci == CI_W'(CHANNEL_NUM_IN - 1));
  assign w_co_last  = (r_co == CO_W'(CHANNEL_NUM_OUT - 1));
  assign w_keep     = ((32'(r_row) % STRIDE) == 0) && ((32'(r_col) % STRIDE) == 0);
  assign w_idx      = IDX_W'((32'(r_row) / STRIDE) * OUT_W + (32'(r_col) / STRIDE));

  // Raster position counters: col -> row -> input channel -> output channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_ci  <= '0;
      r_co  <= '0;
    end else if (valid_in) begin
      if (!w_col_last) begin
        r_col <= r_col + COL_W'(1);
      end else begin
        r_col <= '0;
        if (!w_row_last) begin
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_row <= '0;
          if (!w_ci_last) begin
            r_ci <= r_ci + CI_W'(1);
          end else begin
            r_ci <= '0;
            r_co <= w_co_last ? '0 : r_co + CO_W'(1);
          end
        end
      end
    end
  end

  logic                 r_s1_vld;
  logic [IDX_W-1:0]     r_s1_idx;
  logic [ACC_WIDTH-1:0] r_s1_dat;
  logic                 r_s1_first;
  logic                 r_s1_last;
  logic                 r_s1_plane_end;
  logic                 r_s1_frame_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld       <= 1'b0;
      r_s1_idx       <= '0;
      r_s1_dat       <= '0;
      r_s1_first     <= 1'b0;
      r_s1_last      <= 1'b0;
      r_s1_plane_end <= 1'b0;
      r_s1_frame_end <= 1'b0;
    end else begin
      r_s1_vld       <= valid_in && w_keep;
      r_s1_idx       <= w_idx;
      r_s1_dat       <= ACC_WIDTH'($signed(pxl_in));
      r_s1_first     <= (r_ci == '0);
      r_s1_last      <= w_ci_last;
      r_s1_plane_end <= (w_idx == IDX_W'(OUT_SIZE - 1));
      r_s1_frame_end <= w_co_last;
    end
  end

  // Partial-sum buffer; a given idx is revisited at least OUT_SIZE kept samples later,
  // so the write below always lands before the next read of that entry.
  logic [ACC_WIDTH-1:0] r_mem [OUT_SIZE];

  logic [ACC_WIDTH-1:0] w_acc;
  logic                 w_wr;
  logic                 w_out_vld;

  assign w_acc     = r_s1_first ? r_s1_dat : (r_mem[r_s1_idx] + r_s1_dat);
  assign w_wr      = r_s1_vld && !r_s1_last;
  assign w_out_vld = r_s1_vld && r_s1_last;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_s1_idx] <= w_acc;
    end
  end

  logic [DATA_WIDTH-1:0] w_sat;
  logic [DATA_WIDTH-1:0] w_res;

  if (ACC_WIDTH > DATA_WIDTH) begin : g_sat
    logic [ACC_WIDTH-DATA_WIDTH:0] w_hi;
    assign w_hi = w_acc[ACC_WIDTH-1:DATA_WIDTH-1];
    always_comb begin
      w_sat = w_acc[DATA_WIDTH-1:0];
      // Upper bits not a pure sign extension means the sum left the DATA_WIDTH range.
      if (!((&w_hi) || !(|w_hi))) begin
        w_sat = w_acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end
  end else begin : g_nosat
    assign w_sat = w_acc[DATA_WIDTH-1:0];
  end

`ifdef CONV_CHANNEL_IN_ACCUMULATOR_RELU_EN
  assign w_res = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  logic [DATA_WIDTH-1:0] r_pxl_out;
  logic                  r_valid_out;
  logic                  r_plane_done;
  logic                  r_frame_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pxl_out    <= '0;
      r_valid_out  <= 1'b0;
      r_plane_done <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_out_vld;
      r_plane_done <= w_out_vld && r_s1_plane_end;
      r_frame_done <= w_out_vld && r_s1_plane_end && r_s1_frame_end;
      if (w_out_vld) begin
        r_pxl_out <= w_res;
      end
    end
  end

  assign pxl_out    = r_pxl_out;
  assign valid_out  = r_valid_out;
  assign plane_done = r_plane_done;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_channel_in_accumulator.sv
// Two accumulators (stride 1 and stride 2) share one randomized input stream; a plane-level
// reference model predicts each output and its cycle, and per-instance monitors score them.
module tb_conv_channel_in_accumulator;

  localparam int DW   = 8;
  localparam int AW   = 12;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int CIN  = 4;
  localparam int COUT = 2;
  localparam int FRAME = IW * IH * CIN * COUT;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] pxl_in;

  logic [DW-1:0] po_s1, po_s2;
  logic          vo_s1, vo_s2, pd_s1, pd_s2, fd_s1, fd_s2;

  always #5 clk = ~clk;

  conv_channel_in_accumulator #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
    .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .STRIDE(1)
  ) dut_s1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po_s1), .valid_out(vo_s1), .plane_done(pd_s1), .frame_done(fd_s1)
  );

  conv_channel_in_accumulator #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
    .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .STRIDE(2)
  ) dut_s2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po_s2), .valid_out(vo_s2), .plane_done(pd_s2), .frame_done(fd_s2)
  );

  typedef struct packed {
    int val;
    int cyc;
    bit pd;
    bit fd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n     = 0;
  int acc1[IW*IH];
  int acc2[(IW/2)*(IH/2)];
  logic rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    int r;
    r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`ifdef CONV_CHANNEL_IN_ACCUMULATOR_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // Reference: sample number n fixes (col,row,ci,co); sum kept samples per output pixel.
  task automatic model(input int v);
    int col, row, ci, co, idx;
    exp_t e;
    col = n % IW;
    row = (n / IW) % IH;
    ci  = (n / (IW*IH)) % CIN;
    co  = (n / (IW*IH*CIN)) % COUT;
    n++;
    idx = row * IW + col;
    acc1[idx] = (ci == 0) ? v : acc1[idx] + v;
    if (ci == CIN-1) begin
      e.val = sat(acc1[idx]); e.cyc = cyc + 2;
      e.pd = (idx == IW*IH-1); e.fd = e.pd && (co == COUT-1);
      q1.push_back(e);
    end
    if ((row % 2 == 0) && (col % 2 == 0)) begin
      idx = (row/2) * (IW/2) + col/2;
      acc2[idx] = (ci == 0) ? v : acc2[idx] + v;
      if (ci == CIN-1) begin
        e.val = sat(acc2[idx]); e.cyc = cyc + 2;
        e.pd = (idx == (IW/2)*(IH/2)-1); e.fd = e.pd && (co == COUT-1);
        q2.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit vld, input int v);
    @(posedge clk); #1;
    valid_in = vld;
    pxl_in   = DW'(v);
    if (vld) model(v);
  endtask

  task automatic cmp_out(input string tag, input exp_t e, input logic [DW-1:0] po,
                         input logic pd, input logic fd);
    chk({tag, "_value"}, int'($signed(po)), e.val);
    chk({tag, "_plane_done"}, int'(pd), int'(e.pd));
    chk({tag, "_frame_done"}, int'(fd), int'(e.fd));
    chk({tag, "_latency_cycle"}, cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      chk("s1_valid_in_reset", int'(vo_s1), 0);
      chk("s2_valid_in_reset", int'(vo_s2), 0);
    end else begin
      if (vo_s1) begin
        if (q1.size() == 0) chk("s1_unexpected_output", q1.size(), 1);
        else cmp_out("s1", q1.pop_front(), po_s1, pd_s1, fd_s1);
      end else if (pd_s1 || fd_s1) begin
        chk("s1_pulse_without_valid", int'({pd_s1, fd_s1}), 0);
      end
      if (vo_s2) begin
        if (q2.size() == 0) chk("s2_unexpected_output", q2.size(), 1);
        else cmp_out("s2", q2.pop_front(), po_s2, pd_s2, fd_s2);
      end else if (pd_s2 || fd_s2) begin
        chk("s2_pulse_without_valid", int'({pd_s2, fd_s2}), 0);
      end
    end
  end

  task automatic drain();
    drive(0, $urandom_range(0, 255));
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    chk("s1_drain_pending", q1.size(), 0);
    chk("s2_drain_pending", q2.size(), 0);
  endtask

  task automatic frame_const(input int v);
    for (int i = 0; i < FRAME; i++) drive(1, v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s1_pxl_out", int'(po_s1), 0);
    chk("rst_s1_plane_done", int'(pd_s1), 0);
    chk("rst_s1_frame_done", int'(fd_s1), 0);
    chk("rst_s2_pxl_out", int'(po_s2), 0);
    chk("rst_s2_plane_done", int'(pd_s2), 0);
    chk("rst_s2_frame_done", int'(fd_s2), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    frame_const(1);                                   // unit sum
    drain();
    for (int i = 0; i < FRAME; i++) drive(1, i % (IW*IH));  // raster ramp row*4+col
    drain();
    frame_const(100);                                 // positive saturation
    frame_const(-100);                                // negative saturation
    drain();
    for (int i = 0; i < FRAME; i++) drive(1, (((i / (IW*IH)) % 2) == 0) ? -3 : 1);
    drain();

    for (int i = 0; i < FRAME; i++) begin             // gapped random input
      drive(1, int'($urandom_range(0, 255)) - 128);
      repeat ($urandom_range(0, 2)) drive(0, $urandom_range(0, 255));
    end
    drain();

    for (int i = 0; i < IW*IH + 10; i++) drive(1, 1); // abandon mid-plane at ci=1
    @(posedge clk); #1;
    reset = 1'b1; valid_in = 1'b1; pxl_in = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; valid_in = 1'b0;
    n = 0;
    q1.delete(); q2.delete();
    frame_const(1);
    drain();

    for (int i = 0; i < 2*FRAME; i++) drive(1, int'($urandom_range(0, 255)) - 128);
    drain();
    repeat (5) drive(0, $urandom_range(0, 255));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
